// File: rtl/gpio_seg_pkg.sv
// Shared types and constants for the GPIO 7-segment transmitter.
package gpio_seg_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam int unsigned SEG_W   = 7;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned DIGITS  = 4;
    localparam int unsigned GPIO_W  = 32;
    localparam int unsigned KEY_W   = 3;
    localparam int unsigned SW_W    = 10;
    localparam int unsigned LEDR_W  = 10;

    localparam logic DP_OFF = 1'b1;

    // Active-low segment codes, bit6 = g down to bit0 = a, indexed by hex digit.
    localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/gpio_seg_tx_if.sv
// Board-facing switch/key/LED bundle between the transmitter and its environment.
interface gpio_seg_tx_if;
    import gpio_seg_pkg::*;

    logic [SW_W-1:0]   SW;
    logic [KEY_W-1:0]  KEY;
    logic [LEDR_W-1:0] LEDR;

    modport master (output SW, output KEY, input LEDR);
    modport slave  (input SW, input KEY, output LEDR);

endinterface

// File: rtl/seg7_hex.sv
// Combinational hex digit to active-low 7-segment decoder.
module seg7_hex
    import gpio_seg_pkg::*;
(
    input  logic [3:0]       hex_i,
    output logic [SEG_W-1:0] seg_o
);

    assign seg_o = SEG_TABLE[hex_i];

endmodule

// File: rtl/gpio_seg_tx.sv
// Key-driven 16-bit counter shown as four active-low 7-seg bytes on a tri-stated GPIO header.
module gpio_seg_tx
    import gpio_seg_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic          CLOCK_50,
    input  logic          Reset,
    gpio_seg_tx_if.slave  bus,
    inout  wire  [31:0]   GPIO
);

    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PSC_MAX = PW'(TICK_DIV - 1);

    logic [KEY_W-1:0]  key_s1_q, key_s2_q, key_s3_q;
    logic [KEY_W-1:0]  press_c;
    state_e            state_q, state_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [GPIO_W-1:0] gpio_q, gpio_d;
    logic              oe_q, oe_d;
    logic [LEDR_W-1:0] ledr_q, ledr_d;
    logic              tick_c;
    logic [DIGITS-1:0][SEG_W-1:0] seg_c;

    // Keys idle high; the third stage delays the synchronized level for edge detection.
    assign press_c = key_s3_q & ~key_s2_q;
    assign tick_c  = (state_q == RUN) && (presc_q == PSC_MAX);

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            key_s1_q <= '1;
            key_s2_q <= '1;
            key_s3_q <= '1;
            state_q  <= OFF;
            presc_q  <= '0;
            count_q  <= '0;
            gpio_q   <= 32'hC0C0C0C0;
            oe_q     <= 1'b0;
            ledr_q   <= '0;
        end else begin
            key_s1_q <= bus.KEY;
            key_s2_q <= key_s1_q;
            key_s3_q <= key_s2_q;
            state_q  <= state_d;
            presc_q  <= presc_d;
            count_q  <= count_d;
            gpio_q   <= gpio_d;
            oe_q     <= oe_d;
            ledr_q   <= ledr_d;
        end
    end

    // Output-enable toggle takes priority over run/hold when both arrive together.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            OFF: begin
                if (press_c[2]) state_d = HOLD;
            end
            HOLD: begin
                if (press_c[2])      state_d = OFF;
                else if (press_c[1]) state_d = RUN;
            end
            RUN: begin
                if (press_c[2])      state_d = OFF;
                else if (press_c[1]) state_d = HOLD;
            end
            default: state_d = OFF;
        endcase
    end

    // Load beats tick; prescaler only advances while running.
    always_comb begin
        presc_d = '0;
        count_d = count_q;
        if (press_c[0]) begin
            count_d = CNT_W'(bus.SW);
        end else if (state_q == RUN) begin
            if (tick_c) begin
                count_d = count_q + 16'd1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        seg7_hex u_seg (
            .hex_i (count_q[4*i +: 4]),
            .seg_o (seg_c[i])
        );
    end

    always_comb begin
        gpio_d = {DP_OFF, seg_c[3], DP_OFF, seg_c[2], DP_OFF, seg_c[1], DP_OFF, seg_c[0]};
        oe_d   = (state_d != OFF);
        ledr_d = {count_d[7:0], (state_d == RUN), (state_d != OFF)};
    end

    assign bus.LEDR = ledr_q;
    assign GPIO     = oe_q ? gpio_q : {GPIO_W{1'bz}};

endmodule

// File: doc/gpio_seg_tx.md
GPIO_SEG_TX -- requirements
Module: gpio_seg_tx

Interface
REQ-001 Parameter TICK_DIV, default 50000000, CLOCK_50 cycles per count step (legal range >= 2).
REQ-002 CLOCK_50  input  1  sole clock, all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 SW  input  10  load value.
REQ-005 KEY  input  3  active-low pushbuttons: KEY[0] load, KEY[1] run/hold toggle, KEY[2] output-enable toggle.
REQ-006 GPIO  inout  32  40-pin header: bytes carry active-low 7-seg codes, digit3 in [31:24] down to digit0 in [7:0].
REQ-007 LEDR  output  10  status: LEDR[0] driving, LEDR[1] running, LEDR[9:2] = count[7:0].

Function
REQ-008 KEY inputs SHALL each pass through a 2-flop synchronizer followed by a press detector (sync 1->0), giving a 1-cycle pulse per press.
REQ-009 The action of a press SHALL take effect on the 3rd rising edge after KEY is first sampled low, and a held key SHALL produce exactly one pulse.
REQ-010 FSM states: OFF, HOLD, RUN.
REQ-011 KEY[2] pulse: OFF->HOLD; HOLD->OFF; RUN->OFF.
REQ-012 KEY[1] pulse: HOLD->RUN; RUN->HOLD; ignored in OFF.
REQ-013 KEY[1] and KEY[2] pulses in the same cycle: KEY[2] transition applies, KEY[1] is discarded.
REQ-014 KEY[0] pulse in any state: count <= {6'b0, SW}, prescaler <= 0.
REQ-015 Prescaler SHALL count 0..TICK_DIV-1 only in RUN, wrapping to 0 and asserting a 1-cycle tick on the cycle it equals TICK_DIV-1.
REQ-016 Prescaler SHALL be held at 0 in OFF and HOLD, so every RUN entry starts a full TICK_DIV period.
REQ-017 16-bit count SHALL increment on tick, with FFFF->0000 wrap.
REQ-018 Load and tick in the same cycle: load wins, no increment.
REQ-019 Count SHALL be retained across OFF/HOLD/RUN transitions.
REQ-020 Segment registers SHALL update one cycle after count changes (1-cycle latency count->GPIO).
REQ-021 Active-low codes 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex, bit6=g..bit0=a).
REQ-022 GPIO bits 7,15,23,31 SHALL be driven 1 (DP off) whenever driving.
REQ-023 In OFF, all 32 GPIO bits SHALL be Z, and in HOLD/RUN all 32 SHALL be driven from registers.
REQ-024 Output enable SHALL be registered, with GPIO going Z or driven on the same edge the FSM enters/leaves OFF.

Reset
REQ-025 Reset SHALL dominate all other inputs in its cycle.
REQ-026 Reset values: state OFF, count 0000, prescaler 0, segment registers 40 (digit 0), GPIO all Z, LEDR 0, synchronizers 1 (released), no pulse generated on release.
REQ-027 Reset mid-RUN SHALL abandon the pending tick, and the following cycle SHALL show the reset values.

Structure
REQ-028 Package gpio_seg_pkg SHALL hold: state enum (OFF, HOLD, RUN), 16-entry segment code constant table, DP_OFF constant.
REQ-029 Sub-module seg7_hex (4-bit in, 7-bit active-low out, combinational), instantiated 4 times.
REQ-030 Top-level SHALL contain synchronizers, press detectors, FSM, prescaler, counter, output registers and tri-state assign.

Verification (TICK_DIV=4)
REQ-031 Assert Reset 2 cycles -> GPIO = all Z, LEDR = 0, state OFF.
REQ-032 Press KEY[2] -> within 3 cycles state HOLD, next cycle GPIO = 32'hC0C0C0C0, LEDR[0]=1.
REQ-033 In HOLD, SW=10'h123, press KEY[0] -> count 0123, one cycle later GPIO = 32'hC0F9A4B0.
REQ-034 Load 3FE, press KEY[1] -> RUN, GPIO digits show 03FF 4 cycles later, 0400 after 8, LEDR[1]=1.
REQ-035 Force load pulse on the cycle tick asserts -> count = SW value, no increment, prescaler restarts at 0.
REQ-036 In RUN press KEY[1]+KEY[2] together -> OFF, GPIO all Z, then KEY[2] -> HOLD displaying the retained count.
